// File: rtl/iob_cache_axi_pkg.sv
// Shared definitions for the cache AXI back-end channels (read and write).
package iob_cache_axi_pkg;

  // AXI burst type and response encodings used by both channels
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Back-end channel controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDRESS = 2'd1,
    READ    = 2'd2,
    END     = 2'd3
  } axi_ch_state_t;

endpackage

// File: rtl/iob_cache_read_channel_axi.sv
// Cache back-end AXI4 read channel: fetches one full cache line per replace
// request as a single INCR burst and streams each beat into the data memory.
// A burst containing any non-OKAY beat is re-requested in full.
module iob_cache_read_channel_axi
  import iob_cache_axi_pkg::*;
#(
  parameter int             FE_ADDR_W            = 32,
  parameter int             FE_DATA_W            = 32,
  parameter int             BE_ADDR_W            = 32,
  parameter int             BE_DATA_W            = 32,
  parameter int             WORD_OFFSET_W        = 2,
  parameter int             AXI_ID_W             = 1,
  parameter int             AXI_ID               = 0,
  parameter int             AXI_LEN_W            = 8,
  parameter logic [3:0]     CACHE_AXI_CACHE_MODE = 4'b0011,
  localparam int            BE_NBYTES            = BE_DATA_W / 8,
  localparam int            BE_NBYTES_W          = $clog2(BE_NBYTES),
  localparam int            LINE2BE_W            = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int            IDX_W                = (LINE2BE_W > 0) ? LINE2BE_W : 1,
  localparam int            LADDR_W              = FE_ADDR_W - (BE_NBYTES_W + LINE2BE_W)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  // cache controller side
  input  logic                 replace_valid_i,
  input  logic [LADDR_W-1:0]   replace_addr_i,
  output logic                 replace_o,
  output logic                 read_valid_o,
  output logic [IDX_W-1:0]     read_addr_o,
  output logic [BE_DATA_W-1:0] read_data_o,
  // AXI read address channel
  output logic [AXI_ID_W-1:0]  axi_arid_o,
  output logic [BE_ADDR_W-1:0] axi_araddr_o,
  output logic [AXI_LEN_W-1:0] axi_arlen_o,
  output logic [2:0]           axi_arsize_o,
  output logic [1:0]           axi_arburst_o,
  output logic [1:0]           axi_arlock_o,
  output logic [3:0]           axi_arcache_o,
  output logic [2:0]           axi_arprot_o,
  output logic [3:0]           axi_arqos_o,
  output logic                 axi_arvalid_o,
  input  logic                 axi_arready_i,
  // AXI read data channel
  input  logic [AXI_ID_W-1:0]  axi_rid_i,
  input  logic [BE_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]           axi_rresp_i,
  input  logic                 axi_rlast_i,
  input  logic                 axi_rvalid_i,
  output logic                 axi_rready_o
);

  // Byte offset of a line inside the back-end address space
  localparam int OFFS_W = BE_NBYTES_W + LINE2BE_W;

  axi_ch_state_t        state_q;
  logic [IDX_W-1:0]     word_cnt_q;
  logic [IDX_W-1:0]     word_cnt_d;
  logic                 err_q;
  logic                 err_d;
  logic                 arvalid_q;
  logic                 rready_q;
  logic                 replace_q;
  logic                 beat_bad;
  logic [FE_ADDR_W-1:0] line_byte_addr;

  // Read ID is not used to route beats: only one burst is ever outstanding
  logic unused_rid;
  assign unused_rid = &{1'b0, axi_rid_i};

  // Fixed AR attributes: one INCR burst of full-width beats per line
  assign axi_arid_o    = AXI_ID_W'(AXI_ID);
  assign axi_arlen_o   = AXI_LEN_W'((1 << LINE2BE_W) - 1);
  assign axi_arsize_o  = 3'(BE_NBYTES_W);
  assign axi_arburst_o = AXI_BURST_INCR;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = CACHE_AXI_CACHE_MODE;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;

  // Line-aligned byte address, taken straight from the held request address
  assign line_byte_addr = FE_ADDR_W'(replace_addr_i) << OFFS_W;
  assign axi_araddr_o   = BE_ADDR_W'(line_byte_addr);

  // Registered handshake controls
  assign axi_arvalid_o = arvalid_q;
  assign axi_rready_o  = rready_q;
  assign replace_o     = replace_q;

  // Beats are written into the line as they arrive, at the running index
  assign read_valid_o = (state_q == READ) & axi_rvalid_i;
  assign read_addr_o  = word_cnt_q;
  assign read_data_o  = axi_rdata_i;

  // Next beat index (a single-beat line always writes index 0) and sticky error
  assign beat_bad   = (axi_rresp_i != AXI_RESP_OKAY);
  assign err_d      = err_q | beat_bad;
  assign word_cnt_d = (LINE2BE_W == 0) ? '0 : word_cnt_q + IDX_W'(1);

  // Line-fill controller: AR issue, beat collection, retry on error, done pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      replace_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (replace_valid_i) begin
            state_q    <= ADDRESS;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b1;
            replace_q  <= 1'b1;
          end
        end
        ADDRESS: begin
          if (axi_arready_i) begin
            state_q   <= READ;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        READ: begin
          if (axi_rvalid_i) begin
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            // rlast closes the burst regardless of how many beats were counted
            if (axi_rlast_i) begin
              rready_q <= 1'b0;
              if (err_d) begin
                // Refetch the whole line from the same address
                state_q    <= ADDRESS;
                word_cnt_q <= '0;
                err_q      <= 1'b0;
                arvalid_q  <= 1'b1;
              end else begin
                state_q <= END;
              end
            end
          end
        end
        END: begin
          state_q   <= IDLE;
          replace_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          replace_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
